muldiv_sequencer: RTL and testbench

Iterative unsigned multiply/divide sequencer for the RV32 core. It takes one MUL, DIVU or REMU request, runs a fixed 32-iteration shift-add or restoring-divide loop, and uses the shared ALU for every add or subtract step. It sits beside the execute stage and owns the ALU operand/fop lines only while busy; the external ALU-input mux selects it via `alu_req`.

---
 rtl/muldiv_sequencer.sv | 68 ++++++
 tb/tb_muldiv_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative 32-bit MUL/DIVU/REMU driving the shared ALU for each add/sub step
module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        alu_req,
  output logic [31:0] alu_rda,
  output logic [31:0] alu_rdb,
  output logic [3:0]  alu_fop,
  input  logic [31:0] alu_result
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [4:0] cnt;
  logic [1:0] op_r;
  logic [31:0] x, y, z, x_n, y_n, z_n;
  logic [32:0] s;
  logic ge, run, mul;
  assign run = state == RUN;
  assign mul = op_r == 2'd0;
  assign busy = state != IDLE;
  assign alu_req = busy;
  assign done = state == DONE;
  assign s = {z, x[31]};
  assign ge = s[32] | (s[31:0] >= y);
  always_comb begin
    state_n = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (cnt == 5'd31 ? DONE : RUN) : IDLE;
    alu_rda = run ? (mul ? z : s[31:0]) : 32'd0;
    alu_rdb = run ? (mul ? x : y) : 32'd0;
    alu_fop = run && !mul ? 4'd1 : 4'd0;
    x_n = mul ? x << 1 : {x[30:0], ge};
    y_n = mul ? y >> 1 : y;
    z_n = mul ? (y[0] ? alu_result : z) : (ge ? alu_result : s[31:0]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 5'd0;
      op_r <= 2'd0;
      x <= 32'd0;
      y <= 32'd0;
      z <= 32'd0;
      result <= 32'd0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        op_r <= op;
        cnt <= 5'd0;
        x <= a;
        y <= b;
        z <= 32'd0;
      end else if (run) begin
        cnt <= cnt + 5'd1;
        x <= x_n;
        y <= y_n;
        z <= z_n;
        if (cnt == 5'd31)
          result <= op_r == 2'd0 ? z_n : op_r == 2'd1 ? x_n : op_r == 2'd2 ? z_n : 32'd0;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer with an ideal combinational ALU
module tb_muldiv_sequencer;
  logic clk = 0, rst = 1, start = 0;
  logic [1:0] op = 0;
  logic [31:0] a = 0, b = 0;
  logic busy, done, alu_req;
  logic [31:0] result, alu_rda, alu_rdb, alu_result;
  logic [3:0] alu_fop;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign alu_result = alu_fop == 4'd1 ? alu_rda - alu_rdb : alu_rda + alu_rdb;
  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .alu_req(alu_req),
    .alu_rda(alu_rda), .alu_rdb(alu_rdb), .alu_fop(alu_fop), .alu_result(alu_result)
  );
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic [31:0] res, output int bc, output int fb, output logic idle);
    lat = -1; bc = 0; fb = 0; res = 'x;
    op = o; a = x; b = y; start = 1;
    @(posedge clk); #1;
    start = 0; op = 2'd3; a = $urandom; b = $urandom;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(negedge clk);
      bc += int'(busy);
      if (i <= 32 && alu_fop !== (o == 2'd0 ? 4'd0 : 4'd1)) fb++;
      if (done === 1'b1) begin lat = i; res = result; end
    end
    @(negedge clk);
    idle = !busy;
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (alu_req !== 0) begin errors++; $display("FAIL reset_alu_req: got %b expected 0", alu_req); end
    checks++; if (result !== 0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if ({alu_rda, alu_rdb, alu_fop} !== 68'd0) begin errors++; $display("FAIL reset_alu_out: got %h %h %h expected 0", alu_rda, alu_rdb, alu_fop); end
    rst = 0;
  endtask
  task automatic test_mul();
    int lat, bc, fb; logic [31:0] r; logic idle;
    do_op(2'd0, 32'd7, 32'd6, lat, r, bc, fb, idle);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d expected 33", lat); end
    checks++; if (r !== 32'd42) begin errors++; $display("FAIL mul_7x6: got %h expected %h", r, 32'd42); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected 33", bc); end
    checks++; if (fb !== 0) begin errors++; $display("FAIL mul_fop: got %0d bad cycles expected 0", fb); end
    checks++; if (idle !== 1) begin errors++; $display("FAIL mul_idle_after: got %b expected 1", idle); end
    do_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, r, bc, fb, idle);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL mul_ffff: got %h expected 00000001", r); end
    do_op(2'd0, 32'h10000, 32'h10000, lat, r, bc, fb, idle);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL mul_overflow: got %h expected 00000000", r); end
  endtask
  task automatic test_div();
    int lat, bc, fb; logic [31:0] r; logic idle;
    do_op(2'd1, 32'd100, 32'd7, lat, r, bc, fb, idle);
    checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu_100_7: got %h expected %h", r, 32'd14); end
    checks++; if (fb !== 0) begin errors++; $display("FAIL divu_fop: got %0d bad cycles expected 0", fb); end
    do_op(2'd2, 32'd100, 32'd7, lat, r, bc, fb, idle);
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu_100_7: got %h expected %h", r, 32'd2); end
    do_op(2'd1, 32'hFFFFFFFF, 32'd1, lat, r, bc, fb, idle);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_max_1: got %h expected ffffffff", r); end
    do_op(2'd2, 32'hFFFFFFFF, 32'h80000000, lat, r, bc, fb, idle);
    checks++; if (r !== 32'h7FFFFFFF) begin errors++; $display("FAIL remu_max_msb: got %h expected 7fffffff", r); end
    do_op(2'd3, 32'd100, 32'd7, lat, r, bc, fb, idle);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL op3_result: got %h expected 00000000", r); end
  endtask
  task automatic test_div_zero();
    int lat, bc, fb; logic [31:0] r; logic idle;
    do_op(2'd1, 32'h1234, 32'd0, lat, r, bc, fb, idle);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_by_zero: got %h expected ffffffff", r); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_by_zero_latency: got %0d expected 33", lat); end
    do_op(2'd2, 32'h1234, 32'd0, lat, r, bc, fb, idle);
    checks++; if (r !== 32'h1234) begin errors++; $display("FAIL remu_by_zero: got %h expected 00001234", r); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL remu_by_zero_latency: got %0d expected 33", lat); end
  endtask
  task automatic test_ignore_start();
    int lat, bc, fb, dn, dat; logic [31:0] r, r0; logic idle;
    dn = 0; dat = -1; r0 = 'x;
    op = 2'd0; a = 32'd7; b = 32'd6; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin dn++; dat = i; r0 = result; end
      start = (i == 5 || i == 33); op = 2'd1; a = 32'd1000; b = 32'd3;
    end
    @(negedge clk);
    checks++; if (dn !== 1 || dat !== 33) begin errors++; $display("FAIL ignore_done: got %0d pulses at %0d expected 1 at 33", dn, dat); end
    checks++; if (r0 !== 32'd42) begin errors++; $display("FAIL ignore_result: got %h expected %h", r0, 32'd42); end
    checks++; if (busy !== 0) begin errors++; $display("FAIL ignore_idle: got busy %b expected 0", busy); end
    do_op(2'd1, 32'd100, 32'd7, lat, r, bc, fb, idle);
    checks++; if (lat !== 33 || r !== 32'd14) begin errors++; $display("FAIL back_to_back: got lat %0d result %h expected 33 %h", lat, r, 32'd14); end
  endtask
  task automatic test_reset_in_run();
    int lat, bc, fb; logic [31:0] r; logic idle;
    op = 2'd0; a = 32'd9; b = 32'd9; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (10) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++; if (busy !== 0 || alu_req !== 0) begin errors++; $display("FAIL rst_run_busy: got %b/%b expected 0/0", busy, alu_req); end
    checks++; if (result !== 0) begin errors++; $display("FAIL rst_run_result: got %h expected 0", result); end
    checks++; if (done !== 0) begin errors++; $display("FAIL rst_run_done: got %b expected 0", done); end
    do_op(2'd2, 32'd100, 32'd7, lat, r, bc, fb, idle);
    checks++; if (lat !== 33 || r !== 32'd2) begin errors++; $display("FAIL rst_then_op: got lat %0d result %h expected 33 %h", lat, r, 32'd2); end
    rst = 1; start = 1; op = 2'd0; a = 32'd3; b = 32'd3;
    @(negedge clk);
    rst = 0; start = 0;
    @(negedge clk);
    checks++; if (busy !== 0) begin errors++; $display("FAIL rst_start_same: got busy %b expected 0", busy); end
  endtask
  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_reset_in_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
